// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//     - word offsets of the TXDATA and STATUS registers inside the window
//     - bit positions of the STATUS word
//     - the 2-bit TX FSM state encoding
// ---------------------------------------------------------------------------
package mmio_pkg;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_FULL_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

endpackage : mmio_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with synchronous active-high reset.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Pushes while full and pops while empty are ignored.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     push_i, din_i  write strobe and data
//     pop_i          read strobe (advances head)
//     dout_o         current head entry (combinational)
//     full_o         no free entries
//     empty_o        no valid entries
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   // Equal low bits with differing wrap bits means the writer lapped the reader.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i  && !empty_o;

   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule : sync_fifo

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the processor store stream.
//   Bytes written to TXDATA are queued in a FIFO and serialised on tx;
//   STATUS reports {overflow, full, empty, busy} and clears overflow on a
//   write with bit 0 set.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     MemWrite       store strobe
//     DataAdr        byte address
//     WriteData      store data (TXDATA uses bits [7:0])
//     ReadData       STATUS word when DataAdr selects STATUS, else 0
//     hit            DataAdr falls inside the TXDATA/STATUS window
//     tx             serial line, idle high (registered)
//     busy           high from START entry through the last STOP cycle
//     dbg_state_o    current TX FSM state, for observation only
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        hit,
   output logic        tx,
   output logic        busy,
   output tx_state_e   dbg_state_o
);

   localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
   localparam int          BAUD_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

   // ---------------- address decode ----------------
   logic sel_txdata;
   logic sel_status;
   logic push;
   logic clr_ovf;

   assign sel_txdata = (DataAdr == TXDATA_ADDR);
   assign sel_status = (DataAdr == STATUS_ADDR);
   assign hit        = sel_txdata || sel_status;
   assign push       = MemWrite && sel_txdata;
   assign clr_ovf    = MemWrite && sel_status && WriteData[0];

   // Only the low byte of a TXDATA store and bit 0 of a STATUS store matter.
   logic unused_wdata;
   assign unused_wdata = ^WriteData[31:8];

   // ---------------- FIFO ----------------
   logic       fifo_pop;
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (fifo_pop),
      .din_i   (WriteData[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------- overflow flag ----------------
   logic overflow_q, overflow_d;

   // A dropped push outranks a clear landing on the same edge.
   always_comb begin
      overflow_d = overflow_q;
      if (clr_ovf)           overflow_d = 1'b0;
      if (push && fifo_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   // ---------------- TX FSM ----------------
   tx_state_e         state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              busy_q;

   // The FSM only takes a byte while idle, based on pre-edge FIFO contents.
   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  shift_q <= fifo_dout;
                  bit_q   <= '0;
                  baud_q  <= BAUD_RELOAD;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_q == '0) begin
                  baud_q  <= BAUD_RELOAD;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            S_DATA: begin
               if (baud_q == '0) begin
                  baud_q <= BAUD_RELOAD;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     // shift_q[0] is the bit on the line; [1] is next.
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            S_STOP: begin
               if (baud_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx          = tx_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

   // ---------------- STATUS read ----------------
   logic [31:0] status_w;

   always_comb begin
      status_w                 = '0;
      status_w[STAT_BUSY_BIT]  = busy_q;
      status_w[STAT_EMPTY_BIT] = fifo_empty;
      status_w[STAT_FULL_BIT]  = fifo_full;
      status_w[STAT_OVF_BIT]   = overflow_q;
   end

   assign ReadData = sel_status ? status_w : 32'd0;

endmodule : mmio_uart_tx

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
//   Stimulus pushes expected bytes into exp_q; an independent monitor
//   decodes frames from tx and pops/compares them. Inputs change on the
//   falling edge; outputs are sampled on the falling edge or #1 after rise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mmio_uart_tx;
   import mmio_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] STAT = 32'hFFFF_0004;
   localparam int          CPB  = 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        hit;
   logic        tx;
   logic        busy;
   tx_state_e   dbg_state;

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .hit         (hit),
      .tx          (tx),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks (entered and left on a falling edge) ----------------
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      @(negedge clk);
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
   endtask

   task automatic read_status(output logic [31:0] data, output logic h);
      DataAdr = STAT;
      #1;
      data = ReadData;
      h    = hit;
      DataAdr = '0;
   endtask

   task automatic check_status(input string name, input logic [31:0] exp);
      logic [31:0] d;
      logic        h;
      read_status(d, h);
      check(name, d, exp);
   endtask

   task automatic wait_idle(input int max_cyc);
      int run = 0;
      for (int i = 0; i < max_cyc && run < 3; i++) begin
         @(negedge clk);
         run = busy ? 0 : run + 1;
      end
      check("idle_reached", 32'(run >= 3), 32'd1);
   endtask

   // ---------------- monitor ----------------
   logic       mon_ok;
   logic [7:0] mon_byte;
   logic       mon_stop;
   logic       chk_gap = 1'b0;
   int         last_start = -1;

   task automatic mon_wait(input int n);
      repeat (n) begin
         @(negedge clk);
         if (reset) mon_ok = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            mon_ok = 1'b1;
            if (chk_gap && last_start >= 0)
               check("frame_spacing", 32'(cyc_cnt - last_start), 32'd41);
            last_start = cyc_cnt;
            mon_wait(CPB + CPB / 2);
            for (int i = 0; i < 8; i++) begin
               mon_byte[i] = tx;
               mon_wait(CPB);
            end
            mon_stop = tx;
            if (mon_ok) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
               end else begin
                  check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                  check("stop_bit", {31'd0, mon_stop}, 32'd1);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   logic        rh;
   logic [7:0]  b55;
   int          mism;
   int          busy_cnt;
   logic        exp_tx;

   initial begin
      // Reset held for two edges.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      read_status(rd, rh);
      check("reset_status", rd, 32'h2);
      check("reset_hit_status", {31'd0, rh}, 32'd1);
      DataAdr = BASE; #1;
      check("hit_txdata", {31'd0, hit}, 32'd1);
      check("read_txdata_zero", ReadData, 32'd0);
      DataAdr = '0;

      // Single 0x55 with junk in the upper bits: exact waveform.
      b55 = 8'h55;
      exp_q.push_back(8'h55);
      MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'hDEAD_BE55;
      @(posedge clk); #1;
      check("tx_high_at_write_edge", {31'd0, tx}, 32'd1);
      @(negedge clk);
      MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      mism = 0; busy_cnt = 0;
      for (int k = 1; k <= 41; k++) begin
         @(posedge clk); #1;
         if (k <= 4)       exp_tx = 1'b0;
         else if (k <= 36) exp_tx = b55[(k - 5) / 4];
         else              exp_tx = 1'b1;
         if (tx !== exp_tx) mism++;
         if (busy === 1'b1) busy_cnt++;
         if (k == 41) check("busy_low_after_frame", {31'd0, busy}, 32'd0);
      end
      check("frame_wave_mismatches", 32'(mism), 32'd0);
      check("busy_cycles", 32'(busy_cnt), 32'd40);
      @(negedge clk);
      wait_idle(200);

      // Ten back-to-back writes: 0x00..0x08 sent, 0x09 dropped.
      last_start = -1;
      chk_gap = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 9) exp_q.push_back(8'(i));
         bus_wr(BASE, 32'(i));
      end
      check_status("status_after_ten", 32'hD);
      wait_idle(1000);
      chk_gap = 1'b0;
      check_status("status_after_drain", 32'hA);
      check("queue_empty_after_ten", 32'(exp_q.size()), 32'd0);

      // Clear overflow, then a write outside the window.
      bus_wr(STAT, 32'h1);
      check_status("status_after_clear", 32'h2);
      DataAdr = 32'hFFFF_0008; #1;
      check("hit_outside", {31'd0, hit}, 32'd0);
      check("read_outside_zero", ReadData, 32'd0);
      DataAdr = '0;
      bus_wr(32'hFFFF_0008, 32'hAB);
      busy_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("no_frame_outside", 32'(busy_cnt), 32'd0);
      check_status("status_unchanged", 32'h2);

      // Overflow flag: clear, then dropped push re-sets it.
      for (int i = 0; i < 10; i++) begin
         if (i < 9) exp_q.push_back(8'(8'h10 + i));
         bus_wr(BASE, 32'(8'h10 + i));
      end
      check_status("ovf_full_status", 32'hD);
      bus_wr(STAT, 32'h1);
      check_status("ovf_cleared_full", 32'h5);
      bus_wr(BASE, 32'h77);
      check_status("ovf_set_again", 32'hD);
      bus_wr(STAT, 32'hFFFF_FFFE);
      check_status("ovf_bit0_zero_no_clear", 32'hD);
      wait_idle(1000);
      check("queue_empty_after_ovf", 32'(exp_q.size()), 32'd0);
      bus_wr(STAT, 32'h1);
      check_status("status_idle_clean", 32'h2);

      // Reset during DATA bit 3 of 0xA5 with two bytes queued.
      bus_wr(BASE, 32'hA5);
      bus_wr(BASE, 32'h11);
      bus_wr(BASE, 32'h22);
      repeat (15) @(negedge clk);
      check("pre_reset_state", 32'(dbg_state), 32'(S_DATA));
      check("pre_reset_bit3", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_tx_high", {31'd0, tx}, 32'd1);
      check("abort_busy_low", {31'd0, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_status("status_after_abort", 32'h2);
      busy_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("no_frames_after_abort", 32'(busy_cnt), 32'd0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "timeout");
   end

endmodule : tb_mmio_uart_tx
